// File: rtl/logic_alu_pkg.sv
// Shared opcode/func3 constants and the legality check for the logical-op unit.
package logic_alu_pkg;

    localparam logic [6:0] OPCODE_R  = 7'b0110011;
    localparam logic [6:0] OPCODE_I  = 7'b0010011;
    localparam logic [2:0] FUNC3_XOR = 3'b100;
    localparam logic [2:0] FUNC3_OR  = 3'b110;
    localparam logic [2:0] FUNC3_AND = 3'b111;

    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    function automatic logic is_logic_op(input logic [6:0] opcode, input logic [2:0] func3);
        logic opc_ok;
        logic f3_ok;
        opc_ok = (opcode == OPCODE_R) || (opcode == OPCODE_I);
        f3_ok  = (func3 == FUNC3_XOR) || (func3 == FUNC3_OR) || (func3 == FUNC3_AND);
        return opc_ok && f3_ok;
    endfunction

endpackage

// File: rtl/logic_alu_arbiter_logic_unit.sv
// Combinational XOR/OR/AND unit; anything else yields zero and flags illegal.
module logic_unit
    import logic_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    always_comb begin
        illegal = !is_logic_op(opcode, func3);
        result  = '0;
        if (!illegal) begin
            case (func3)
                FUNC3_XOR: result = op1 ^ op2;
                FUNC3_OR:  result = op1 | op2;
                FUNC3_AND: result = op1 & op2;
                default:   result = '0;
            endcase
        end
    end

endmodule

// File: rtl/logic_alu_arbiter.sv
// Two-port round-robin front end for one shared logic unit, with a one-entry
// registered response slot that supports back-to-back reload under backpressure.
module logic_alu_arbiter
    import logic_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_op1,
    input  logic [XLEN-1:0]  req0_op2,
    input  logic [6:0]       req0_opcode,
    input  logic [2:0]       req0_func3,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_op1,
    input  logic [XLEN-1:0]  req1_op2,
    input  logic [6:0]       req1_opcode,
    input  logic [2:0]       req1_func3,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_src,
    output logic             rsp_illegal
);

    logic             prio;
    logic             can_accept;
    logic             gnt0_p0;
    logic             gnt1_p0;
    logic             vld_p0;
    logic [XLEN-1:0]  op1_p0;
    logic [XLEN-1:0]  op2_p0;
    logic [6:0]       opcode_p0;
    logic [2:0]       func3_p0;
    logic [TAG_W-1:0] tag_p0;
    logic [XLEN-1:0]  result_p0;
    logic             illegal_p0;

    logic             vld_p1;
    logic [XLEN-1:0]  result_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             src_p1;
    logic             illegal_p1;

    // Stage p0: arbitration and operand select
    assign can_accept = (vld_p1 == SLOT_EMPTY) || rsp_ready;

    // rst_n gating keeps both readys low while reset is held.
    assign gnt0_p0 = rst_n && can_accept && req0_valid && (!req1_valid || !prio);
    assign gnt1_p0 = rst_n && can_accept && req1_valid && (!req0_valid ||  prio);
    assign vld_p0  = gnt0_p0 || gnt1_p0;

    assign req0_ready = gnt0_p0;
    assign req1_ready = gnt1_p0;

    assign op1_p0    = gnt1_p0 ? req1_op1    : req0_op1;
    assign op2_p0    = gnt1_p0 ? req1_op2    : req0_op2;
    assign opcode_p0 = gnt1_p0 ? req1_opcode : req0_opcode;
    assign func3_p0  = gnt1_p0 ? req1_func3  : req0_func3;
    assign tag_p0    = gnt1_p0 ? req1_tag    : req0_tag;

    logic_unit #(
        .XLEN (XLEN)
    ) u_logic_unit (
        .op1     (op1_p0),
        .op2     (op2_p0),
        .opcode  (opcode_p0),
        .func3   (func3_p0),
        .result  (result_p0),
        .illegal (illegal_p0)
    );

    // Stage p1: response slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= SLOT_EMPTY;
            result_p1  <= '0;
            tag_p1     <= '0;
            src_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
            prio       <= 1'b0;
        end else if (vld_p0) begin
            vld_p1     <= SLOT_FULL;
            result_p1  <= result_p0;
            tag_p1     <= tag_p0;
            src_p1     <= gnt1_p0;
            illegal_p1 <= illegal_p0;
            prio       <= gnt0_p0;
        end else if (rsp_ready) begin
            vld_p1     <= SLOT_EMPTY;
        end
    end

    assign rsp_valid   = vld_p1;
    assign rsp_result  = result_p1;
    assign rsp_tag     = tag_p1;
    assign rsp_src     = src_p1;
    assign rsp_illegal = illegal_p1;

endmodule

// File: tb/tb_logic_alu_arbiter.sv
// Bench for logic_alu_arbiter: behavioural model with per-cycle compare plus directed literal checks.
module tb_logic_alu_arbiter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [XLEN-1:0]  req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [6:0]       req0_opcode = '0, req1_opcode = '0;
    logic [2:0]       req0_func3 = '0, req1_func3 = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [XLEN-1:0]  rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_src;
    logic             rsp_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_alu_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_opcode(req0_opcode), .req0_func3(req0_func3), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_opcode(req1_opcode), .req1_func3(req1_func3), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_src(rsp_src), .rsp_illegal(rsp_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one operation, straight from the opcode table.
    task automatic calc(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r, output logic ill);
        r   = 32'h0;
        ill = 1'b1;
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            ill = 1'b0;
            case (f3)
                3'b100:  r = a ^ b;
                3'b110:  r = a | b;
                3'b111:  r = a & b;
                default: ill = 1'b1;
            endcase
        end
    endtask

    // Model state: who is favoured next and what the slot holds.
    logic        m_prio = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_result = '0;
    logic [3:0]  m_tag = '0;
    logic        m_src = 1'b0;
    logic        m_ill = 1'b0;

    function automatic int winner();
        if (!rst_n) return -1;
        if (m_valid && !rsp_ready) return -1;
        if (req0_valid && req1_valid) return m_prio ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prio = 1'b0; m_valid = 1'b0; m_result = '0; m_tag = '0; m_src = 1'b0; m_ill = 1'b0;
        end else begin
            int w;
            w = winner();
            if (w == 0) begin
                calc(req0_opcode, req0_func3, req0_op1, req0_op2, m_result, m_ill);
                m_tag = req0_tag; m_src = 1'b0; m_valid = 1'b1; m_prio = 1'b1;
            end else if (w == 1) begin
                calc(req1_opcode, req1_func3, req1_op1, req1_op2, m_result, m_ill);
                m_tag = req1_tag; m_src = 1'b1; m_valid = 1'b1; m_prio = 1'b0;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        w = winner();
        chk("m_ready0", 32'(req0_ready), 32'(w == 0));
        chk("m_ready1", 32'(req1_ready), 32'(w == 1));
        chk("m_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("m_result", rsp_result, m_result);
            chk("m_tag", 32'(rsp_tag), 32'(m_tag));
            chk("m_src", 32'(rsp_src), 32'(m_src));
            chk("m_illegal", 32'(rsp_illegal), 32'(m_ill));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        req0_valid = v; req0_opcode = opc; req0_func3 = f3; req0_op1 = a; req0_op2 = b; req0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        req1_valid = v; req1_opcode = opc; req1_func3 = f3; req1_op1 = a; req1_op2 = b; req1_tag = t;
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] r, input logic [3:0] t,
                              input logic s, input logic ill);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_result"}, rsp_result, r);
        chk({name, "_tag"}, 32'(rsp_tag), 32'(t));
        chk({name, "_src"}, 32'(rsp_src), 32'(s));
        chk({name, "_illegal"}, 32'(rsp_illegal), 32'(ill));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        ill;

        // Pin the model against hand-computed values.
        calc(7'b0110011, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, r, ill);
        chk("pin_xor", r, 32'hFF00_FF00);
        calc(7'b0010011, 3'b111, 32'h1234_5678, 32'hFFFF_F00F, r, ill);
        chk("pin_andi", r, 32'h1234_5008);
        calc(7'b0110011, 3'b000, 32'hFFFF_FFFF, 32'h1, r, ill);
        chk("pin_add_ill", 32'(ill), 32'd1);

        // Reset state, with a requester valid to show ready stays low.
        req0_valid = 1'b1;
        #2;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single XOR from req0.
        rsp_ready = 1'b1;
        set0(1'b1, 7'b0110011, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd3);
        #1 chk("single_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        expect_rsp("single", 32'hFF00_FF00, 4'd3, 1'b0, 1'b0);

        // Immediate AND from req1 (returns prio to req0).
        set1(1'b1, 7'b0010011, 3'b111, 32'h1234_5678, 32'hFFFF_F00F, 4'd6);
        tick();
        req1_valid = 1'b0;
        expect_rsp("andi", 32'h1234_5008, 4'd6, 1'b1, 1'b0);

        // Contention: both valid for four cycles.
        set0(1'b1, 7'b0110011, 3'b110, 32'd1, 32'd2, 4'd1);
        set1(1'b1, 7'b0110011, 3'b111, 32'd7, 32'd5, 4'd2);
        for (int i = 0; i < 4; i++) begin
            #1 chk("cont_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            tick();
            if (i % 2 == 0) expect_rsp("cont", 32'd3, 4'd1, 1'b0, 1'b0);
            else            expect_rsp("cont", 32'd5, 4'd2, 1'b1, 1'b0);
        end

        // Backpressure: slot holds, no readys.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", 32'(req0_ready), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            tick();
            expect_rsp("bp_hold", 32'd5, 4'd2, 1'b1, 1'b0);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready0", 32'(req0_ready), 32'd1);
        tick();
        expect_rsp("bp_next", 32'd3, 4'd1, 1'b0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'd0);

        // Illegal ops from each requester.
        set0(1'b1, 7'b0110011, 3'b000, 32'hFFFF, 32'h1, 4'd9);
        tick();
        req0_valid = 1'b0;
        expect_rsp("ill_add", 32'd0, 4'd9, 1'b0, 1'b1);
        set1(1'b1, 7'b0000011, 3'b100, 32'hAAAA, 32'h5555, 4'd10);
        tick();
        req1_valid = 1'b0;
        expect_rsp("ill_load", 32'd0, 4'd10, 1'b1, 1'b1);
        tick();

        // Reset mid-stream with the slot full and stalled.
        rsp_ready = 1'b0;
        set0(1'b1, 7'b0110011, 3'b110, 32'hF0, 32'h0F, 4'd4);
        tick();
        req0_valid = 1'b0;
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_result", rsp_result, 32'd0);
        chk("midrst_tag", 32'(rsp_tag), 32'd0);
        chk("midrst_illegal", 32'(rsp_illegal), 32'd0);
        tick();
        rsp_ready = 1'b1;
        set0(1'b1, 7'b0110011, 3'b100, 32'hFF, 32'h0F, 4'd5);
        set1(1'b1, 7'b0110011, 3'b111, 32'hFF, 32'h0F, 4'd7);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(req0_ready), 32'd1);
        chk("post_rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        expect_rsp("post_rst", 32'hF0, 4'd5, 1'b0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_alu_arbiter.md
# logic_alu_arbiter

Shares one logical-operation unit (XOR/OR/AND, register and immediate forms) between two requesters in the execute stage, such as the main issue port and a second issue/replay port. Round-robin arbitration with valid/ready handshakes on both inputs, a one-entry registered result slot with backpressure, and tagged responses so each requester can match returning results.

## Interface
Parameters:
- XLEN, 32, operand/result width
- TAG_W, 4, width of the requester-supplied tag

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 presents an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op1  input  XLEN  rs1 value
- req0_op2  input  XLEN  rs2 or immediate
- req0_opcode  input  7  instruction[6:0]
- req0_func3  input  3  instruction[14:12]
- req0_tag  input  TAG_W  opaque tag, returned with result
- req1_valid / req1_ready / req1_op1 / req1_op2 / req1_opcode / req1_func3 / req1_tag: identical to requester 0
- rsp_valid  output  1  result slot holds a response
- rsp_ready  input  1  consumer accepts response this cycle
- rsp_result  output  XLEN  logical result
- rsp_tag  output  TAG_W  tag of the producing request
- rsp_src  output  1  0 = requester 0, 1 = requester 1
- rsp_illegal  output  1  opcode/func3 not a logical op; rsp_result is 0

## Operation
- Legal ops: opcode 0110011 (R) or 0010011 (I) with func3 100 = XOR, 110 = OR, 111 = AND. All other combinations are illegal: result 32'h0, rsp_illegal = 1, still returned as a normal response.
- Result slot states: EMPTY (rsp_valid = 0), FULL (rsp_valid = 1).
- can_accept = !rsp_valid || rsp_ready.
- Arbitration: priority pointer prio (reset 0). When can_accept, grant goes to the only valid requester, or to requester prio when both are valid. No grant when can_accept = 0.
- reqN_ready = grant to N; combinational from reqN_valid, prio, rsp_valid, rsp_ready. At most one ready is high per cycle. A ready is never high while the corresponding valid is low.
- On a grant: the slot loads result, tag, src, illegal; rsp_valid = 1; prio = other requester (1 - granted index).
- Slot drains when rsp_valid && rsp_ready with no new grant: rsp_valid goes to 0.
- Simultaneous drain and grant: the slot reloads in the same edge, with no bubble.
- Slot contents are held stable while rsp_valid && !rsp_ready.
- Requesters must hold valid and payload until ready. The block does not check this.

## Timing
- Latency: response is visible one cycle after the accepting edge (registered output).
- Throughput: 1 op/cycle with rsp_ready held high. Two continuously valid requesters alternate 0,1,0,1 starting from prio.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system): rsp_valid = 0, rsp_result = 0, rsp_tag = 0, rsp_src = 0, rsp_illegal = 0, prio = 0.
- reqN_ready is 0 during reset.
- Reset mid-operation discards the slot contents with no response.
- No combinational path from rsp_ready to rsp_* outputs. The only such paths are rsp_ready to reqN_ready.

## Structure
- Shared package logic_alu_pkg: OPCODE_R, OPCODE_I, FUNC3_XOR, FUNC3_OR, FUNC3_AND localparams; a function or constant for the illegal-op check.
- One combinational sub-module logic_unit (op1, op2, opcode, func3 -> result, illegal), instanced once after the grant mux.
- The top level holds the grant mux, the prio register and the result slot.

## Test plan
- Single op: req0 XOR op1 = 32'hF0F0_F0F0, op2 = 32'h0FF0_0FF0, tag = 3, rsp_ready = 1 -> next cycle rsp_valid = 1, result 32'hFF00_FF00, tag 3, src 0, illegal 0.
- Contention: both valid every cycle for 4 cycles (req0 OR 1|2, req1 AND 7&5), rsp_ready = 1 -> grants 0,1,0,1; results 3,5,3,5; src 0,1,0,1.
- Backpressure: rsp_ready = 0 for 3 cycles with both requesters valid -> slot holds the first result unchanged, both readys 0; on rsp_ready = 1 the next grant goes to the other requester, with no bubble.
- Illegal: opcode 0110011, func3 000 (ADD) or opcode 0000011, func3 100 -> result 0, rsp_illegal = 1, tag returned.
- Immediate form: opcode 0010011, func3 111, op1 = 32'h1234_5678, op2 = 32'hFFFF_F00F -> result 32'h1234_5008.
- Reset mid-stream: assert rst_n = 0 while rsp_valid = 1 and rsp_ready = 0 -> all outputs 0 immediately. After release with both valid, the first grant goes to req0.
